// File: rtl/program_result_monitor_if.sv
// Bus bundle for program_result_monitor: store snoop, expected-table load and verdict outputs.
// The master side drives the core/bench signals and the slave side is the monitor.
interface program_result_monitor_if #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int IW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
);
    logic                  Start;
    logic                  MemEn;
    logic                  MemWrite;
    logic [XLEN-1:0]       MemAdr;
    logic [XLEN-1:0]       MemWriteData;
    logic                  InstrValid;
    logic                  ExpectedWe;
    logic [IW-1:0]         ExpectedIdx;
    logic [XLEN-1:0]       ExpectedData;
    logic                  Done;
    logic                  Pass;
    logic                  Fail;
    logic [2:0]            Status;
    logic [IW-1:0]         FailIdx;
    logic [XLEN-1:0]       FailData;
    logic [NUM_CHECKS-1:0] ChecksSeen;
    logic [CNT_WIDTH-1:0]  CycleCount;

    modport master (
        output Start, MemEn, MemWrite, MemAdr, MemWriteData, InstrValid,
        output ExpectedWe, ExpectedIdx, ExpectedData,
        input  Done, Pass, Fail, Status, FailIdx, FailData, ChecksSeen, CycleCount
    );

    modport slave (
        input  Start, MemEn, MemWrite, MemAdr, MemWriteData, InstrValid,
        input  ExpectedWe, ExpectedIdx, ExpectedData,
        output Done, Pass, Fail, Status, FailIdx, FailData, ChecksSeen, CycleCount
    );
endinterface

// File: rtl/program_result_monitor.sv
// End-of-program checker: compares stores to a window of result slots against an expected table
// and latches one sticky verdict. Define PROGRAM_RESULT_MONITOR_ORDERED_EN to require ascending slot order.
module program_result_monitor #(
    parameter int              XLEN            = 32,
    parameter int              NUM_CHECKS      = 4,
    parameter logic [XLEN-1:0] RESULT_BASE_ADR = XLEN'(32'hC),
    parameter int              ADR_STRIDE      = 4,
    parameter int              TIMEOUT_CYCLES  = 100000,
    parameter int              CNT_WIDTH       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    program_result_monitor_if.slave  mon
);
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int SW = (ADR_STRIDE > 1) ? $clog2(ADR_STRIDE) : 0;

    localparam logic [XLEN-1:0]       STRIDE_MASK  = XLEN'(ADR_STRIDE - 1);
    localparam logic [XLEN-1:0]       WINDOW_BYTES = XLEN'(NUM_CHECKS * ADR_STRIDE);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX      = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1'b1);
    localparam logic [NUM_CHECKS-1:0] ALL_SEEN     = {NUM_CHECKS{1'b1}};
    localparam logic [NUM_CHECKS-1:0] SLOT0_BIT    = NUM_CHECKS'(1'b1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_STARVED = 3'd5;

    logic [2:0]            state_r;
    logic [2:0]            state_nx_s;
    logic [XLEN-1:0]       expected_r [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] seen_r;
    logic [NUM_CHECKS-1:0] seen_nx_s;
    logic [CNT_WIDTH-1:0]  cycle_cnt_r;
    logic [IW-1:0]         fail_idx_r;
    logic [XLEN-1:0]       fail_data_r;
    logic                  done_r;
    logic                  pass_r;
    logic                  fail_r;
    logic [XLEN-1:0]       offset_s;
    logic [IW-1:0]         hit_idx_s;
    logic                  hit_s;
    logic                  mismatch_s;
    logic                  order_err_s;
    logic                  bad_store_s;

    function automatic logic is_terminal(input logic [2:0] st);
        logic term;
        case (st)
            ST_PASS, ST_FAIL, ST_TIMEOUT, ST_STARVED: term = 1'b1;
            default:                                  term = 1'b0;
        endcase
        return term;
    endfunction

    function automatic logic is_failure(input logic [2:0] st);
        logic fl;
        case (st)
            ST_FAIL, ST_TIMEOUT, ST_STARVED: fl = 1'b1;
            default:                         fl = 1'b0;
        endcase
        return fl;
    endfunction

`ifdef PROGRAM_RESULT_MONITOR_ORDERED_EN
    // Lowest slot not yet matched; slots complete contiguously from 0 in ordered mode.
    function automatic logic [IW-1:0] lowest_unseen(input logic [NUM_CHECKS-1:0] seen);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            idx = seen[i] ? idx : IW'(i);
        end
        return idx;
    endfunction
`endif

    // Store decode against the slot window; an address below the base wraps to a large offset.
    always_comb begin
        offset_s   = mon.MemAdr - RESULT_BASE_ADR;
        hit_s      = mon.MemEn & mon.MemWrite & (offset_s < WINDOW_BYTES) &
                     ((offset_s & STRIDE_MASK) == {XLEN{1'b0}});
        hit_idx_s  = IW'(offset_s >> SW);
        mismatch_s = hit_s & (mon.MemWriteData != expected_r[hit_idx_s]);
`ifdef PROGRAM_RESULT_MONITOR_ORDERED_EN
        order_err_s = hit_s & ~seen_r[hit_idx_s] & (hit_idx_s != lowest_unseen(seen_r));
`else
        order_err_s = 1'b0;
`endif
        bad_store_s = mismatch_s | order_err_s;
    end

    // Next-state and slot tracking; event priority FAIL > PASS > STARVED > TIMEOUT.
    always_comb begin
        state_nx_s = state_r;
        seen_nx_s  = seen_r;
        case (state_r)
            ST_IDLE: begin
                if (mon.Start) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hit_s && !bad_store_s) begin
                    seen_nx_s = seen_r | (SLOT0_BIT << hit_idx_s);
                end else begin
                    seen_nx_s = seen_r;
                end
                if (bad_store_s) begin
                    state_nx_s = ST_FAIL;
                end else if (seen_nx_s == ALL_SEEN) begin
                    state_nx_s = ST_PASS;
                end else if (!mon.InstrValid) begin
                    state_nx_s = ST_STARVED;
                end else if (cycle_cnt_r == TIMEOUT_LAST) begin
                    state_nx_s = ST_TIMEOUT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT, ST_STARVED: begin
                state_nx_s = state_r;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Verdict state, run counter, first-failure capture and decoded status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            seen_r      <= {NUM_CHECKS{1'b0}};
            cycle_cnt_r <= {CNT_WIDTH{1'b0}};
            fail_idx_r  <= {IW{1'b0}};
            fail_data_r <= {XLEN{1'b0}};
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            seen_r  <= seen_nx_s;
            if ((state_r == ST_RUN) && (cycle_cnt_r != CNT_MAX)) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if ((state_r == ST_RUN) && bad_store_s) begin
                fail_idx_r  <= hit_idx_s;
                fail_data_r <= mon.MemWriteData;
            end else begin
                fail_idx_r  <= fail_idx_r;
                fail_data_r <= fail_data_r;
            end
            done_r <= is_terminal(state_nx_s);
            pass_r <= (state_nx_s == ST_PASS);
            fail_r <= is_failure(state_nx_s);
        end
    end

    // Expected table lives outside reset so a rerun after reset needs no reload.
    generate
        if (NUM_CHECKS == (1 << IW)) begin : g_full_table
            // Table write; every index value addresses a real slot.
            always_ff @(posedge clk) begin
                if (mon.ExpectedWe) begin
                    expected_r[mon.ExpectedIdx] <= mon.ExpectedData;
                end
            end
        end else begin : g_partial_table
            // Table write; indices past the last slot are dropped.
            always_ff @(posedge clk) begin
                if (mon.ExpectedWe && (int'(mon.ExpectedIdx) < NUM_CHECKS)) begin
                    expected_r[mon.ExpectedIdx] <= mon.ExpectedData;
                end
            end
        end
    endgenerate

    assign mon.Status     = state_r;
    assign mon.Done       = done_r;
    assign mon.Pass       = pass_r;
    assign mon.Fail       = fail_r;
    assign mon.FailIdx    = fail_idx_r;
    assign mon.FailData   = fail_data_r;
    assign mon.ChecksSeen = seen_r;
    assign mon.CycleCount = cycle_cnt_r;

endmodule

// File: tb/tb_program_result_monitor.sv
// Self-checking bench for program_result_monitor: directed scenarios then randomized runs, all
// checked every cycle against a slot-level behavioural model of the verdict rules.
module tb_program_result_monitor;
    localparam int NSLOT   = 4;
    localparam int BASE    = 12;
    localparam int STRIDE  = 4;
    localparam int TIMEOUT = 20;
`ifdef PROGRAM_RESULT_MONITOR_ORDERED_EN
    localparam bit ORDERED = 1'b1;
`else
    localparam bit ORDERED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    // model state: 0 IDLE 1 RUN 2 PASS 3 FAIL 4 TIMEOUT 5 STARVED
    int          m_status = 0;
    logic [3:0]  m_seen = 4'h0;
    logic [31:0] m_cnt = 32'h0;
    logic [31:0] m_fidx = 32'h0;
    logic [31:0] m_fdata = 32'h0;
    logic [31:0] m_exp [NSLOT];

    program_result_monitor_if #(.XLEN(32), .NUM_CHECKS(NSLOT), .CNT_WIDTH(32)) bus ();

    program_result_monitor #(
        .XLEN(32), .NUM_CHECKS(NSLOT), .RESULT_BASE_ADR(32'hC), .ADR_STRIDE(STRIDE),
        .TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mon(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock of the verdict rules applied to the inputs the DUT is about to sample.
    task automatic model_step();
        longint a;
        int     slot;
        bit     hit;
        bit     bad;
        if (reset) begin
            m_status = 0; m_seen = 4'h0; m_cnt = 32'h0; m_fidx = 32'h0; m_fdata = 32'h0;
        end else if (m_status == 0) begin
            if (bus.Start) m_status = 1;
        end else if (m_status == 1) begin
            a   = longint'(bus.MemAdr);
            hit = bus.MemEn && bus.MemWrite && (a >= BASE) && (a < BASE + NSLOT * STRIDE) &&
                  (((a - BASE) % STRIDE) == 0);
            bad = 1'b0;
            if (hit) begin
                slot = int'((a - BASE) / STRIDE);
                bad  = (bus.MemWriteData !== m_exp[slot]);
                if (ORDERED && !m_seen[slot])
                    for (int k = 0; k < slot; k++) if (!m_seen[k]) bad = 1'b1;
                if (bad) begin
                    m_fidx  = 32'(slot);
                    m_fdata = bus.MemWriteData;
                end else begin
                    m_seen[slot] = 1'b1;
                end
            end
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (bad)                  m_status = 3;
            else if (m_seen == 4'hF)  m_status = 2;
            else if (!bus.InstrValid) m_status = 5;
            else if (m_cnt == 32'(TIMEOUT)) m_status = 4;
        end
        if (bus.ExpectedWe) m_exp[bus.ExpectedIdx] = bus.ExpectedData;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("Status",     32'(bus.Status),     32'(m_status));
        check("Done",       32'(bus.Done),       32'(m_status >= 2));
        check("Pass",       32'(bus.Pass),       32'(m_status == 2));
        check("Fail",       32'(bus.Fail),       32'(m_status >= 3));
        check("ChecksSeen", 32'(bus.ChecksSeen), 32'(m_seen));
        check("CycleCount", bus.CycleCount,      m_cnt);
        check("FailIdx",    32'(bus.FailIdx),    m_fidx);
        check("FailData",   bus.FailData,        m_fdata);
    endtask

    task automatic idle_bus();
        bus.Start = 1'b0; bus.MemEn = 1'b0; bus.MemWrite = 1'b0;
        bus.MemAdr = 32'h0; bus.MemWriteData = 32'h0; bus.InstrValid = 1'b1;
        bus.ExpectedWe = 1'b0; bus.ExpectedIdx = 2'd0; bus.ExpectedData = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        bus.ExpectedWe = 1'b1; bus.ExpectedIdx = 2'(idx); bus.ExpectedData = data;
        step();
        bus.ExpectedWe = 1'b0;
    endtask

    task automatic start_run();
        bus.Start = 1'b1; step(); bus.Start = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        bus.MemEn = 1'b1; bus.MemWrite = 1'b1; bus.MemAdr = adr; bus.MemWriteData = data;
        step();
        bus.MemEn = 1'b0; bus.MemWrite = 1'b0;
    endtask

    initial begin
        int          sl;
        logic [31:0] adr;
        for (int k = 0; k < NSLOT; k++) m_exp[k] = 32'h0;
        idle_bus();

        // reset state
        do_reset();
        check("reset_status", 32'(bus.Status), 32'd0);
        check("reset_done",   32'(bus.Done),   32'd0);

        // in-order pass
        load(0, 32'h0F); load(1, 32'h1); load(2, 32'h2); load(3, 32'h3);
        start_run();
        store(32'hC, 32'h0F);  check("seen_1", 32'(bus.ChecksSeen), 32'h1);
        store(32'h10, 32'h1);  check("seen_2", 32'(bus.ChecksSeen), 32'h3);
        store(32'h14, 32'h2);  check("seen_3", 32'(bus.ChecksSeen), 32'h7);
        store(32'h18, 32'h3);
        check("pass_status", 32'(bus.Status), 32'd2);
        check("pass_flag",   32'(bus.Pass),   32'd1);
        step(); step();

        // mismatch, then a correct store leaves the verdict alone
        do_reset(); start_run();
        store(32'hC, 32'h0E);
        check("mm_status", 32'(bus.Status),  32'd3);
        check("mm_fdata",  bus.FailData,     32'h0E);
        store(32'hC, 32'h0F);
        check("mm_sticky", 32'(bus.Status),  32'd3);

        // out-of-window / misaligned stores, then timeout 20 cycles into RUN
        do_reset(); start_run();
        store(32'h8, 32'h0F); store(32'h1C, 32'h3); store(32'hE, 32'h0F);
        check("oow_seen", 32'(bus.ChecksSeen), 32'h0);
        for (int c = 3; c < TIMEOUT; c++) step();
        check("to_status", 32'(bus.Status),  32'd4);
        check("to_count",  bus.CycleCount,   32'd20);
        step();

        // starvation in the 5th RUN cycle freezes the count at 5
        do_reset(); start_run();
        for (int c = 0; c < 4; c++) step();
        bus.InstrValid = 1'b0; step(); bus.InstrValid = 1'b1;
        check("starve_status", 32'(bus.Status), 32'd5);
        check("starve_count",  bus.CycleCount,  32'd5);
        step();

        // final matching store with InstrValid low: PASS outranks STARVED
        do_reset(); start_run();
        store(32'hC, 32'h0F); store(32'h10, 32'h1); store(32'h14, 32'h2);
        bus.InstrValid = 1'b0; store(32'h18, 32'h3); bus.InstrValid = 1'b1;
        check("prio_status", 32'(bus.Status), 32'd2);

        // reset mid-run; table retained (slot 3 rewritten while reset is high)
        do_reset(); start_run();
        store(32'hC, 32'h0F); store(32'h10, 32'h1);
        check("mid_seen", 32'(bus.ChecksSeen), 32'h3);
        bus.ExpectedWe = 1'b1; bus.ExpectedIdx = 2'd3; bus.ExpectedData = 32'h33;
        do_reset();
        bus.ExpectedWe = 1'b0;
        check("mid_reset_seen", 32'(bus.ChecksSeen), 32'h0);
        start_run();
        store(32'hC, 32'h0F); store(32'h10, 32'h1); store(32'h14, 32'h2); store(32'h18, 32'h33);
        check("rerun_status", 32'(bus.Status), 32'd2);

        // same-cycle table write does not affect that cycle's compare
        do_reset(); start_run();
        bus.ExpectedWe = 1'b1; bus.ExpectedIdx = 2'd0; bus.ExpectedData = 32'h55;
        store(32'hC, 32'h0F);
        bus.ExpectedWe = 1'b0;
        check("oldval_seen", 32'(bus.ChecksSeen), 32'h1);
        store(32'hC, 32'h0F);
        check("newval_fail", 32'(bus.Status), 32'd3);
        load(0, 32'h0F); load(3, 32'h3);

        // ordering: slot 2 first
        do_reset(); start_run();
        store(32'h14, 32'h2); store(32'hC, 32'h0F); store(32'h10, 32'h1); store(32'h18, 32'h3);
        check("order_status", 32'(bus.Status), ORDERED ? 32'd3 : 32'd2);

        // randomized runs against the model
        for (int r = 0; r < 30; r++) begin
            idle_bus();
            do_reset();
            if ($urandom_range(0, 1) == 1)
                for (int k = 0; k < NSLOT; k++) load(k, 32'($urandom_range(0, 7)));
            start_run();
            for (int c = 0; c < 24; c++) begin
                sl  = int'($urandom_range(0, 6)) - 1;
                adr = 32'(BASE + sl * STRIDE);
                if ($urandom_range(0, 7) == 0) adr = adr + 32'd1;
                if ($urandom_range(0, 15) == 0) adr = $urandom;
                bus.MemEn        = ($urandom_range(0, 3) != 0);
                bus.MemWrite     = ($urandom_range(0, 3) != 0);
                bus.MemAdr       = adr;
                bus.MemWriteData = m_exp[(sl >= 0 && sl < NSLOT) ? sl : 0];
                if ($urandom_range(0, 7) == 0) bus.MemWriteData = 32'($urandom_range(0, 7));
                bus.InstrValid   = ($urandom_range(0, 31) != 0);
                bus.ExpectedWe   = ($urandom_range(0, 15) == 0);
                bus.ExpectedIdx  = 2'($urandom_range(0, 3));
                bus.ExpectedData = 32'($urandom_range(0, 7));
                bus.Start        = ($urandom_range(0, 7) == 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/program_result_monitor.md
Name: program_result_monitor

Overview:
- Synthesizable end-of-program checker for core-level regression.
- Snoops the core's data-memory write port and compares stores to a window of result slots against preloaded expected values.
- Generalises the single-address, single-value check to NUM_CHECKS slots.
- Adds a cycle timeout and instruction-starvation detection, and reports one sticky terminal verdict to the bench or an FPGA status LED.

Parameters:
XLEN, 32, data/address width (matches BIT_COUNT)
NUM_CHECKS, 4, number of result slots (1..32)
RESULT_BASE_ADR, 32'hC, byte address of slot 0
ADR_STRIDE, 4, byte spacing between consecutive slots (power of 2)
TIMEOUT_CYCLES, 100000, RUN cycles allowed before timeout
CNT_WIDTH, 32, width of CycleCount

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
Start  in  1  arms monitor (IDLE->RUN)
MemEn  in  1  data-memory access valid
MemWrite  in  1  access is a store
MemAdr  in  XLEN  store byte address
MemWriteData  in  XLEN  store data
InstrValid  in  1  instruction memory returned a valid word this cycle
ExpectedWe  in  1  write expected-value table
ExpectedIdx  in  IW  table index, IW = max(1,$clog2(NUM_CHECKS))
ExpectedData  in  XLEN  expected value
Done  out  1  terminal state reached
Pass  out  1  all slots matched
Fail  out  1  mismatch, timeout or starvation
Status  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 STARVED
FailIdx  out  IW  slot of first mismatch
FailData  out  XLEN  data of first mismatching store
ChecksSeen  out  NUM_CHECKS  per-slot matched bits
CycleCount  out  CNT_WIDTH  RUN cycles elapsed

Behaviour:
- Reset behaviour:
  - On reset: state IDLE; ChecksSeen=0, CycleCount=0, FailIdx=0, FailData=0; Done=Pass=Fail=0.
  - Reset mid-run returns to IDLE on the next edge.
  - The expected table is NOT reset. ExpectedWe writes are accepted in every state, including while reset is high.
- IDLE:
  - Bus ignored.
  - Start=1 -> RUN next cycle.
- RUN, slot hit:
  - Hit = MemEn & MemWrite & MemAdr in [BASE, BASE+NUM_CHECKS*STRIDE) & (MemAdr-BASE) aligned to STRIDE.
  - Slot index = (MemAdr-BASE)/STRIDE.
  - Non-hit stores are ignored.
- RUN, compare:
  - Hit with data == expected[idx]: set ChecksSeen[idx].
  - Hit with data != expected[idx]: go to FAIL and capture FailIdx/FailData.
  - A repeat hit to a seen slot is recompared; a mismatch still fails.
  - An ExpectedWe to the same index in the same cycle does not affect that cycle's compare, which uses the old value.
- RUN, other exits:
  - PASS when ChecksSeen becomes all-ones. The transition occurs on the edge after the final matching store (1-cycle latency).
  - STARVED when InstrValid=0 in any RUN cycle.
  - TIMEOUT when CycleCount == TIMEOUT_CYCLES-1 and no other event.
  - CycleCount increments every RUN cycle and saturates at all-ones.
- Priority for same-cycle events: FAIL > PASS > STARVED > TIMEOUT.
- Terminal states (PASS/FAIL/TIMEOUT/STARVED):
  - Sticky until reset.
  - Bus, Start and CycleCount are frozen.
- Outputs (all registered, decoded from state):
  - Done=1 in any terminal state.
  - Pass=1 only in PASS.
  - Fail=1 in FAIL, TIMEOUT and STARVED.

Optional Feature:
- Macro: PROGRAM_RESULT_MONITOR_ORDERED_EN.
- When defined:
  - Slots must be stored in ascending order 0,1,2,…
  - A hit to an index other than the next unseen slot -> FAIL with FailIdx=hit index and FailData=store data, even if the value matches.
  - Repeat stores to already-seen slots are still allowed and recompared.
- When undefined: slots may complete in any order.

Test Plan:
- Common setup: NUM_CHECKS=4, BASE=0xC, STRIDE=4.
- Pass in order: expected {0x0F,0x1,0x2,0x3}; Start; stores to 0xC,0x10,0x14,0x18 with matching data -> ChecksSeen 0001..1111; Pass=Done=1 one cycle after 4th store; Status=2.
- Mismatch: store 0x0E to 0xC (expected 0x0F) -> Fail=1, Status=3, FailIdx=0, FailData=0x0E. A later correct store leaves state unchanged.
- Out-of-window and misaligned: stores to 0x8, 0x1C, 0xE -> no ChecksSeen change. With TIMEOUT_CYCLES=20 and InstrValid=1, Status=4 exactly 20 cycles after entering RUN.
- Starvation and priority:
  - InstrValid=0 at RUN cycle 5 -> Status=5, CycleCount frozen at 5.
  - Final matching store in the same cycle InstrValid drops -> Status=2 (PASS wins).
- Reset and ordering:
  - reset pulsed mid-RUN with ChecksSeen=0011 -> IDLE, ChecksSeen=0, expected table retained. A rerun passes without reloading.
  - With the ordering macro defined: store to 0x14 first -> FAIL, FailIdx=2. Without the macro, the same sequence completes to PASS.
